// File: rtl/uart_cmd_rx_if.sv
// Serial line in, received byte stream out, between the UART receiver and the command unit.
interface uart_cmd_rx_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  io_rxd;
   logic                  io_cmd_valid;
   logic [DATA_WIDTH-1:0] io_cmd_payload;
   logic                  io_frameError;
   logic                  io_busy;

   modport slave (
      input  io_rxd,
      output io_cmd_valid, io_cmd_payload, io_frameError, io_busy
   );

   modport master (
      output io_rxd,
      input  io_cmd_valid, io_cmd_payload, io_frameError, io_busy
   );
endinterface

// File: rtl/uart_cmd_rx.sv
// UART 8N1 receiver: oversampled, majority-voted, one valid pulse per well-framed byte (LSB first).
module uart_cmd_rx #(
   parameter int CLK_DIV    = 4,
   parameter int OVERSAMPLE = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   uart_cmd_rx_if.slave bus
);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int TMR_W = $clog2(OVERSAMPLE);
   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TMR_W-1:0] TMR_FULL = TMR_W'(OVERSAMPLE - 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

   state_t                state_q;
   logic                  sync1_q, sync2_q;
   logic [DIV_W-1:0]      div_q;
   logic [2:0]            hist_q;
   logic [TMR_W-1:0]      tmr_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [DATA_WIDTH-1:0] shreg_q, payload_q;
   logic                  valid_q, ferr_q;

   logic                  tick, sampled;
   logic [DATA_WIDTH:0]   shift_w;

   assign tick    = (div_q == DIV_LAST);
   assign sampled = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
   assign shift_w = {sampled, shreg_q};

   assign bus.io_cmd_valid   = valid_q;
   assign bus.io_cmd_payload = payload_q;
   assign bus.io_frameError  = ferr_q;
   assign bus.io_busy        = (state_q != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         div_q   <= '0;
      end else begin
         sync1_q <= bus.io_rxd;
         sync2_q <= sync1_q;
         div_q   <= tick ? '0 : div_q + 1'b1;
      end
   end

   // The FSM decides on the history as it stood before this tick's shift.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         hist_q    <= 3'b111;
         tmr_q     <= '0;
         cnt_q     <= '0;
         shreg_q   <= '0;
         payload_q <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         if (tick) begin
            hist_q <= {hist_q[1:0], sync2_q};
            case (state_q)
               IDLE: begin
                  if (!sampled) begin
                     state_q <= START;
                     tmr_q   <= TMR_HALF;
                  end
               end
               START: begin
                  if (tmr_q != '0) tmr_q <= tmr_q - 1'b1;
                  else if (sampled) state_q <= IDLE;
                  else begin
                     state_q <= DATA;
                     tmr_q   <= TMR_FULL;
                     cnt_q   <= '0;
                  end
               end
               DATA: begin
                  if (tmr_q != '0) tmr_q <= tmr_q - 1'b1;
                  else begin
                     shreg_q <= shift_w[DATA_WIDTH:1];
                     tmr_q   <= TMR_FULL;
                     if (cnt_q == LAST_BIT) state_q <= STOP;
                     else                   cnt_q   <= cnt_q + 1'b1;
                  end
               end
               STOP: begin
                  if (tmr_q != '0) tmr_q <= tmr_q - 1'b1;
                  else if (sampled) begin
                     payload_q <= shreg_q;
                     valid_q   <= 1'b1;
                     state_q   <= IDLE;
                  end else begin
                     ferr_q  <= 1'b1;
                     state_q <= BRK;
                  end
               end
               BRK: begin
                  if (sampled) state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end
endmodule
